// File: rtl/frog_life_ctrl.sv
// Frog life/score controller: tracks lives and score, and sequences death freeze, respawn and
// post-respawn invulnerability. It also handles game over and restart.
module frog_life_ctrl #(
    parameter int unsigned TILE_SIZE   = 32,
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned DEATH_TICKS = 60,
    parameter int unsigned GRACE_TICKS = 90,
    parameter int unsigned GOAL_Y      = 0,
    parameter int unsigned SPAWN_X     = 304,
    parameter int unsigned SPAWN_Y     = 448
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Tick,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic [9:0] i_Frog_Y,
    output logic       o_Respawn,
    output logic [9:0] o_Spawn_X,
    output logic [9:0] o_Spawn_Y,
    output logic       o_Freeze,
    output logic [2:0] o_Lives,
    output logic [7:0] o_Score,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_lives
        $error("START_LIVES out of range 1..7");
    end
    if (DEATH_TICKS < 1 || DEATH_TICKS > 255 || GRACE_TICKS < 1 || GRACE_TICKS > 255)
    begin : g_bad_ticks
        $error("DEATH_TICKS/GRACE_TICKS out of range 1..255");
    end
    // The whole frog tile must fit inside the 10-bit coordinate space at the spawn point.
    if (TILE_SIZE == 0 || SPAWN_X + TILE_SIZE > 1024 || SPAWN_Y + TILE_SIZE > 1024)
    begin : g_bad_spawn
        $error("spawn tile does not fit the 10-bit coordinate space");
    end

    localparam logic [2:0] StartLives = 3'(START_LIVES);
    localparam logic [7:0] DeathTicks = 8'(DEATH_TICKS);
    localparam logic [7:0] GraceTicks = 8'(GRACE_TICKS);
    localparam logic [9:0] GoalY      = 10'(GOAL_Y);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPlay  = 3'd1,
        StDying = 3'd2,
        StGrace = 3'd3,
        StOver  = 3'd4
    } state_e;

    state_e     state_q;
    logic [2:0] lives_q;
    logic [7:0] score_q;
    logic [7:0] cnt_q;
    logic       respawn_q;
    logic       freeze_q;
    logic       game_over_q;

    logic goal_hit;
    assign goal_hit = (i_Frog_Y == GoalY);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= StIdle;
            lives_q     <= StartLives;
            score_q     <= 8'd0;
            cnt_q       <= 8'd0;
            respawn_q   <= 1'b0;
            freeze_q    <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            case (state_q)
                StIdle, StOver: begin
                    if (i_Start) begin
                        state_q     <= StPlay;
                        lives_q     <= StartLives;
                        score_q     <= 8'd0;
                        cnt_q       <= 8'd0;
                        respawn_q   <= 1'b1;
                        freeze_q    <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                end
                StPlay: begin
                    // Collision takes priority over reaching the goal in the same cycle.
                    if (i_Has_Collided) begin
                        state_q  <= StDying;
                        lives_q  <= (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                        cnt_q    <= DeathTicks;
                        freeze_q <= 1'b1;
                    end else if (goal_hit) begin
                        state_q   <= StGrace;
                        score_q   <= (score_q != 8'hFF) ? score_q + 8'd1 : 8'hFF;
                        cnt_q     <= GraceTicks;
                        respawn_q <= 1'b1;
                    end
                end
                StDying: begin
                    if (i_Tick) begin
                        if (cnt_q == 8'd1) begin
                            if (lives_q == 3'd0) begin
                                state_q     <= StOver;
                                cnt_q       <= 8'd0;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q   <= StGrace;
                                cnt_q     <= GraceTicks;
                                respawn_q <= 1'b1;
                                freeze_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                StGrace: begin
                    if (i_Tick) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= StPlay;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cnt_q       <= 8'd0;
                    freeze_q    <= 1'b1;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Respawn   = respawn_q;
    assign o_Spawn_X   = 10'(SPAWN_X);
    assign o_Spawn_Y   = 10'(SPAWN_Y);
    assign o_Freeze    = freeze_q;
    assign o_Lives     = lives_q;
    assign o_Score     = score_q;
    assign o_Game_Over = game_over_q;
    assign o_State     = state_q;

endmodule

// File: tb/tb_frog_life_ctrl.sv
// Bench for frog_life_ctrl: directed scenarios with literal expectations, then random stimulus
// compared every cycle against a rule-level model of lives, score and timers.
module tb_frog_life_ctrl;

    localparam int START = 3;
    localparam int DEATH = 60;
    localparam int GRACE = 90;

    logic       clk = 1'b0;
    logic       i_Rst, i_Tick, i_Start, i_Has_Collided;
    logic [9:0] i_Frog_Y;
    logic       o_Respawn, o_Freeze, o_Game_Over;
    logic [9:0] o_Spawn_X, o_Spawn_Y;
    logic [2:0] o_Lives, o_State;
    logic [7:0] o_Score;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0 idle, 1 play, 2 dying, 3 grace, 4 over.
    int m_mode, m_lives, m_score, m_timer, m_resp;

    frog_life_ctrl #(
        .TILE_SIZE(32), .START_LIVES(START), .DEATH_TICKS(DEATH), .GRACE_TICKS(GRACE),
        .GOAL_Y(0), .SPAWN_X(304), .SPAWN_Y(448)
    ) dut (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Tick(i_Tick), .i_Start(i_Start),
        .i_Has_Collided(i_Has_Collided), .i_Frog_Y(i_Frog_Y),
        .o_Respawn(o_Respawn), .o_Spawn_X(o_Spawn_X), .o_Spawn_Y(o_Spawn_Y),
        .o_Freeze(o_Freeze), .o_Lives(o_Lives), .o_Score(o_Score),
        .o_Game_Over(o_Game_Over), .o_State(o_State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, start, col, tick, input int fy);
        m_resp = 0;
        if (rst) begin
            m_mode = 0; m_lives = START; m_score = 0; m_timer = 0;
        end else if (m_mode == 0 || m_mode == 4) begin
            if (start) begin
                m_mode = 1; m_lives = START; m_score = 0; m_resp = 1;
            end
        end else if (m_mode == 1) begin
            if (col) begin
                m_mode = 2; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_timer = DEATH;
            end else if (fy == 0) begin
                m_mode = 3; m_score = (m_score < 255) ? m_score + 1 : 255;
                m_timer = GRACE; m_resp = 1;
            end
        end else if (m_mode == 2) begin
            if (tick) begin
                m_timer--;
                if (m_timer == 0) begin
                    if (m_lives == 0) m_mode = 4;
                    else begin
                        m_mode = 3; m_timer = GRACE; m_resp = 1;
                    end
                end
            end
        end else if (m_mode == 3) begin
            if (tick) begin
                m_timer--;
                if (m_timer == 0) m_mode = 1;
            end
        end
    endtask

    task automatic compare_model();
        chk("state", int'(o_State), m_mode);
        chk("lives", int'(o_Lives), m_lives);
        chk("score", int'(o_Score), m_score);
        chk("respawn", int'(o_Respawn), m_resp);
        chk("freeze", int'(o_Freeze), (m_mode == 0 || m_mode == 2 || m_mode == 4) ? 1 : 0);
        chk("game_over", int'(o_Game_Over), (m_mode == 4) ? 1 : 0);
        chk("spawn_x", int'(o_Spawn_X), 304);
        chk("spawn_y", int'(o_Spawn_Y), 448);
    endtask

    task automatic cycle(input bit rst, start, col, tick, input int fy);
        i_Rst = rst; i_Start = start; i_Has_Collided = col; i_Tick = tick;
        i_Frog_Y = 10'(fy);
        model_step(rst, start, col, tick, fy);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Each tick is preceded by an idle cycle so tick gating is exercised too.
    task automatic ticks(input int n, input bit col, input int fy);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, col, 0, fy);
            cycle(0, 0, col, 1, fy);
        end
    endtask

    initial begin
        i_Rst = 1'b1; i_Start = 1'b0; i_Has_Collided = 1'b0; i_Tick = 1'b0; i_Frog_Y = 10'd200;
        @(negedge clk);
        cycle(1, 1, 1, 1, 200);
        chk("rst_state", int'(o_State), 0);
        chk("rst_lives", int'(o_Lives), 3);
        chk("rst_freeze", int'(o_Freeze), 1);
        chk("rst_respawn", int'(o_Respawn), 0);

        cycle(0, 1, 0, 0, 200);
        chk("start_state", int'(o_State), 1);
        chk("start_respawn", int'(o_Respawn), 1);
        chk("start_freeze", int'(o_Freeze), 0);
        cycle(0, 0, 0, 1, 200);
        chk("respawn_one_cycle", int'(o_Respawn), 0);
        chk("play_ignores_tick", int'(o_State), 1);

        cycle(0, 0, 1, 0, 200);
        chk("death_lives", int'(o_Lives), 2);
        chk("death_state", int'(o_State), 2);
        ticks(DEATH - 1, 0, 200);
        chk("dying_59", int'(o_State), 2);
        chk("dying_59_freeze", int'(o_Freeze), 1);
        ticks(1, 0, 200);
        chk("dying_60_respawn", int'(o_Respawn), 1);
        chk("dying_60_state", int'(o_State), 3);
        ticks(GRACE, 0, 200);
        chk("grace_done_state", int'(o_State), 1);

        cycle(0, 0, 0, 0, 0);
        chk("goal_score", int'(o_Score), 1);
        chk("goal_state", int'(o_State), 3);
        chk("goal_respawn", int'(o_Respawn), 1);
        ticks(GRACE, 1, 0);
        chk("grace_invuln_lives", int'(o_Lives), 2);
        chk("grace_invuln_state", int'(o_State), 1);
        cycle(0, 0, 1, 0, 200);
        chk("post_grace_death", int'(o_Lives), 1);

        ticks(DEATH, 1, 200);
        ticks(GRACE, 0, 200);
        cycle(0, 0, 1, 0, 0);
        chk("col_goal_state", int'(o_State), 2);
        chk("col_goal_score", int'(o_Score), 1);
        ticks(DEATH, 0, 200);
        chk("over_state", int'(o_State), 4);
        chk("over_game_over", int'(o_Game_Over), 1);
        chk("over_lives", int'(o_Lives), 0);
        chk("over_no_respawn", int'(o_Respawn), 0);
        cycle(0, 1, 0, 0, 200);
        chk("restart_lives", int'(o_Lives), 3);
        chk("restart_score", int'(o_Score), 0);

        cycle(0, 0, 1, 0, 200);
        ticks(30, 0, 200);
        cycle(1, 1, 1, 1, 200);
        chk("mid_dying_rst_state", int'(o_State), 0);
        chk("mid_dying_rst_lives", int'(o_Lives), 3);
        chk("mid_dying_rst_respawn", int'(o_Respawn), 0);

        for (int i = 0; i < 30000; i++) begin
            bit r, s, c, t;
            int fy;
            r  = ($urandom_range(0, 499) == 0);
            s  = ($urandom_range(0, 19) == 0);
            c  = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 1) == 0);
            fy = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 479));
            cycle(r, s, c, t, fy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frog_life_ctrl.md
FROG_LIFE_CTRL -- requirements
Module: frog_life_ctrl

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 32, meaning frog/car tile edge in pixels (spawn geometry).
REQ-002 SHALL have parameter START_LIVES, default 3, meaning lives loaded at game start; legal range 1..7.
REQ-003 SHALL have parameter DEATH_TICKS, default 60, meaning i_Tick count of the death freeze; legal range 1..255.
REQ-004 SHALL have parameter GRACE_TICKS, default 90, meaning i_Tick count of post-respawn invulnerability; legal range 1..255.
REQ-005 SHALL have parameter GOAL_Y, default 0, meaning frog Y row that counts as goal reached.
REQ-006 SHALL have parameter SPAWN_X, default 304, and SPAWN_Y, default 448, meaning frog respawn top-left corner.
REQ-007 SHALL have i_Clk  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have i_Rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have i_Tick  input  1  one-cycle frame tick; counters advance only on it.
REQ-010 SHALL have i_Start  input  1  start/restart request, level-sampled.
REQ-011 SHALL have i_Has_Collided  input  1  registered frog/car overlap flag.
REQ-012 SHALL have i_Frog_Y  input  10  current frog top-left Y.
REQ-013 SHALL have o_Respawn  output  1  one-cycle pulse: movement block loads o_Spawn_X/Y.
REQ-014 SHALL have o_Spawn_X  output  10, o_Spawn_Y  output  10  constant SPAWN_X/SPAWN_Y.
REQ-015 SHALL have o_Freeze  output  1  frog movement disabled.
REQ-016 SHALL have o_Lives  output  3, o_Score  output  8, o_Game_Over  output  1, o_State  output  3.

Function
REQ-017 SHALL implement FSM IDLE=0, PLAY=1, DYING=2, GRACE=3, OVER=4; o_State = current state.
REQ-018 IDLE: o_Freeze=1; i_Start=1 -> PLAY, o_Lives<=START_LIVES, o_Score<=0, o_Respawn pulsed next cycle.
REQ-019 PLAY, i_Has_Collided=1 -> DYING, o_Lives<=o_Lives-1, tick counter<=DEATH_TICKS.
REQ-020 PLAY, i_Frog_Y==GOAL_Y, no collision -> GRACE, o_Score<=o_Score+1 saturating at 255, o_Respawn pulsed, counter<=GRACE_TICKS.
REQ-021 Collision and goal in same PLAY cycle: collision wins; score unchanged.
REQ-022 DYING: o_Freeze=1; collisions ignored; counter decrements on each i_Tick; at i_Tick with counter==1 -> OVER if o_Lives==0, else GRACE with o_Respawn pulse and counter<=GRACE_TICKS.
REQ-023 GRACE: o_Freeze=0; i_Has_Collided ignored; goal ignored; counter decrements on each i_Tick; at i_Tick with counter==1 -> PLAY.
REQ-024 OVER: o_Freeze=1, o_Game_Over=1; o_Lives=0; o_Score held; i_Start=1 -> same action as REQ-018.
REQ-025 o_Respawn SHALL be exactly one cycle, registered, coincident with first cycle of the entered state.
REQ-026 o_Lives SHALL never underflow; decrement only in REQ-019.
REQ-027 i_Tick ignored in IDLE, PLAY, OVER; counter width 8 bits.
REQ-028 o_Game_Over SHALL be 1 only in OVER.

Reset
REQ-029 i_Rst=1 at any clock edge, any state (incl. mid-DYING) -> IDLE next cycle.
REQ-030 Reset values: o_State=0, o_Lives=START_LIVES, o_Score=0, o_Freeze=1, o_Respawn=0, o_Game_Over=0, counter=0.
REQ-031 i_Rst SHALL dominate i_Start and i_Has_Collided in the same cycle.

Verification
REQ-032 Reset, i_Start 1 cycle -> o_State=1, o_Respawn one-cycle pulse, o_Lives=3, o_Score=0, o_Freeze=0.
REQ-033 PLAY, i_Has_Collided 1 cycle, 60 i_Ticks -> o_Lives=2, o_Freeze=1 throughout DYING, o_Respawn on 60th tick, o_State=3; 90 ticks later o_State=1.
REQ-034 Collision held high through GRACE -> no further life lost until state returns to PLAY, then o_Lives decrements by 1.
REQ-035 Three deaths from START_LIVES=3 -> o_State=4, o_Game_Over=1, o_Lives=0, no o_Respawn; i_Start -> lives 3, score 0.
REQ-036 PLAY, i_Frog_Y=0 and i_Has_Collided=1 same cycle -> DYING, o_Score unchanged; i_Frog_Y=0 alone -> o_Score+1, o_State=3.
REQ-037 i_Rst pulsed mid-DYING at counter=30 -> o_State=0, o_Lives=3, o_Respawn=0 next cycle.
